// File: rtl/fpu_round_arbiter.sv
// Round-robin arbiter that shares one round-to-nearest-even stage between NUM_REQ FPU producers.
// Optional statistics counters are enabled with the FPU_ROUND_STATS_EN macro.

module result_rounder #(
    parameter int EXPONENT_WIDTH = 8,
    parameter int MANTISSA_WIDTH = 23,
    parameter int ROUNDING_BITS  = 3
) (
    input  logic                      sign,
    input  logic [EXPONENT_WIDTH-1:0] exp,
    input  logic [MANTISSA_WIDTH-1:0] mant,
    input  logic [ROUNDING_BITS-1:0]  rbits,
    output logic                      rnd_sign,
    output logic [EXPONENT_WIDTH-1:0] rnd_exp,
    output logic [MANTISSA_WIDTH-1:0] rnd_mant,
    output logic                      rnd_overflow
);

    localparam logic [ROUNDING_BITS-1:0]  HALF_PATTERN = {1'b1, {(ROUNDING_BITS-1){1'b0}}};
    localparam logic [EXPONENT_WIDTH-1:0] EXP_ALL_ONES = {EXPONENT_WIDTH{1'b1}};

    logic                      halfway_s;
    logic                      round_up_s;
    logic [MANTISSA_WIDTH:0]   mant_sum_s;
    logic [EXPONENT_WIDTH-1:0] exp_sum_s;

    // Ties-to-even increment with mantissa carry into the exponent and saturation to infinity
    always_comb begin
        halfway_s  = (rbits == HALF_PATTERN);
        round_up_s = (halfway_s && mant[0]) || (!halfway_s && rbits[ROUNDING_BITS-1]);
        mant_sum_s = {1'b0, mant} + {{MANTISSA_WIDTH{1'b0}}, round_up_s};
        exp_sum_s  = exp + {{(EXPONENT_WIDTH-1){1'b0}}, mant_sum_s[MANTISSA_WIDTH]};
        rnd_sign   = sign;
        if (exp_sum_s == EXP_ALL_ONES) begin
            rnd_exp      = EXP_ALL_ONES;
            rnd_mant     = {MANTISSA_WIDTH{1'b0}};
            rnd_overflow = 1'b1;
        end else begin
            rnd_exp      = exp_sum_s;
            rnd_mant     = mant_sum_s[MANTISSA_WIDTH-1:0];
            rnd_overflow = 1'b0;
        end
    end

endmodule

module fpu_round_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int EXPONENT_WIDTH = 8,
    parameter int MANTISSA_WIDTH = 23,
    parameter int ROUNDING_BITS  = 3,
    parameter int ID_WIDTH       = $clog2(NUM_REQ)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req_valid,
    output logic [NUM_REQ-1:0]                req_ready,
    input  logic [NUM_REQ-1:0]                req_sign,
    input  logic [NUM_REQ*EXPONENT_WIDTH-1:0] req_exp,
    input  logic [NUM_REQ*MANTISSA_WIDTH-1:0] req_mant,
    input  logic [NUM_REQ*ROUNDING_BITS-1:0]  req_rbits,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [ID_WIDTH-1:0]               out_id,
    output logic                              out_sign,
    output logic [EXPONENT_WIDTH-1:0]         out_exp,
    output logic [MANTISSA_WIDTH-1:0]         out_mant,
    output logic                              out_overflow
`ifdef FPU_ROUND_STATS_EN
    ,
    input  logic                              stat_clr,
    output logic [NUM_REQ*16-1:0]             stat_grant_cnt,
    output logic [15:0]                       stat_ovf_cnt
`endif
);

    localparam logic [ID_WIDTH-1:0] LAST_ID = ID_WIDTH'(NUM_REQ - 1);
    localparam logic [ID_WIDTH-1:0] ID_ONE  = {{(ID_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [NUM_REQ-1:0]  REQ_ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic [ID_WIDTH-1:0]       rr_ptr_r;
    logic [ID_WIDTH-1:0]       grant_idx_s;
    logic                      grant_found_s;
    logic                      can_load_s;
    logic                      load_s;
    logic [ID_WIDTH-1:0]       next_ptr_s;

    logic                      sel_sign_s;
    logic [EXPONENT_WIDTH-1:0] sel_exp_s;
    logic [MANTISSA_WIDTH-1:0] sel_mant_s;
    logic [ROUNDING_BITS-1:0]  sel_rbits_s;

    logic                      rnd_sign_s;
    logic [EXPONENT_WIDTH-1:0] rnd_exp_s;
    logic [MANTISSA_WIDTH-1:0] rnd_mant_s;
    logic                      rnd_overflow_s;

    // Find the first valid requester at or after rr_ptr, wrapping around
    always_comb begin : arb_scan
        int   scan_idx_v;
        logic take_v;
        scan_idx_v    = 0;
        take_v        = 1'b0;
        grant_found_s = 1'b0;
        grant_idx_s   = {ID_WIDTH{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx_v    = (int'(rr_ptr_r) + k) % NUM_REQ;
            take_v        = !grant_found_s && req_valid[scan_idx_v];
            grant_idx_s   = take_v ? ID_WIDTH'(scan_idx_v) : grant_idx_s;
            grant_found_s = grant_found_s || take_v;
        end
    end

    // Slot load condition, one-hot grant and pointer advance past the winner
    always_comb begin
        can_load_s = !out_valid || out_ready;
        load_s     = can_load_s && grant_found_s;
        next_ptr_s = (grant_idx_s == LAST_ID) ? {ID_WIDTH{1'b0}} : (grant_idx_s + ID_ONE);
        if (load_s && !rst) begin
            req_ready = REQ_ONE << grant_idx_s;
        end else begin
            req_ready = {NUM_REQ{1'b0}};
        end
    end

    // Route the winner's payload into the shared rounder
    always_comb begin
        sel_sign_s  = req_sign[grant_idx_s];
        sel_exp_s   = req_exp[int'(grant_idx_s)*EXPONENT_WIDTH +: EXPONENT_WIDTH];
        sel_mant_s  = req_mant[int'(grant_idx_s)*MANTISSA_WIDTH +: MANTISSA_WIDTH];
        sel_rbits_s = req_rbits[int'(grant_idx_s)*ROUNDING_BITS +: ROUNDING_BITS];
    end

    result_rounder #(
        .EXPONENT_WIDTH (EXPONENT_WIDTH),
        .MANTISSA_WIDTH (MANTISSA_WIDTH),
        .ROUNDING_BITS  (ROUNDING_BITS)
    ) u_rounder (
        .sign         (sel_sign_s),
        .exp          (sel_exp_s),
        .mant         (sel_mant_s),
        .rbits        (sel_rbits_s),
        .rnd_sign     (rnd_sign_s),
        .rnd_exp      (rnd_exp_s),
        .rnd_mant     (rnd_mant_s),
        .rnd_overflow (rnd_overflow_s)
    );

    // Output slot: load on grant, drain when consumer accepts with nothing pending, hold otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid    <= 1'b0;
            out_id       <= {ID_WIDTH{1'b0}};
            out_sign     <= 1'b0;
            out_exp      <= {EXPONENT_WIDTH{1'b0}};
            out_mant     <= {MANTISSA_WIDTH{1'b0}};
            out_overflow <= 1'b0;
            rr_ptr_r     <= {ID_WIDTH{1'b0}};
        end else if (load_s) begin
            out_valid    <= 1'b1;
            out_id       <= grant_idx_s;
            out_sign     <= rnd_sign_s;
            out_exp      <= rnd_exp_s;
            out_mant     <= rnd_mant_s;
            out_overflow <= rnd_overflow_s;
            rr_ptr_r     <= next_ptr_s;
        end else if (can_load_s) begin
            out_valid    <= 1'b0;
        end
    end

`ifdef FPU_ROUND_STATS_EN
    logic [15:0] grant_cnt_r [NUM_REQ];
    logic [15:0] ovf_cnt_r;

    // Saturating per-requester grant and overflow counters; clear wins over increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                grant_cnt_r[i] <= 16'h0000;
            end
            ovf_cnt_r <= 16'h0000;
        end else if (stat_clr) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                grant_cnt_r[i] <= 16'h0000;
            end
            ovf_cnt_r <= 16'h0000;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (load_s && (grant_idx_s == ID_WIDTH'(i)) && (grant_cnt_r[i] != 16'hFFFF)) begin
                    grant_cnt_r[i] <= grant_cnt_r[i] + 16'h0001;
                end
            end
            if (load_s && rnd_overflow_s && (ovf_cnt_r != 16'hFFFF)) begin
                ovf_cnt_r <= ovf_cnt_r + 16'h0001;
            end
        end
    end

    // Flatten counters onto the packed statistics port
    always_comb begin
        stat_grant_cnt = {(NUM_REQ*16){1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            stat_grant_cnt[i*16 +: 16] = grant_cnt_r[i];
        end
        stat_ovf_cnt = ovf_cnt_r;
    end
`endif

endmodule

// File: tb/tb_fpu_round_arbiter.sv
// Self-checking bench for fpu_round_arbiter: directed vectors, multi-cycle sequences and a randomized model check.

module tb_fpu_round_arbiter;

    localparam int N  = 4;
    localparam int EW = 8;
    localparam int MW = 23;
    localparam int RB = 3;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N-1:0]      req_sign;
    logic [N*EW-1:0]   req_exp;
    logic [N*MW-1:0]   req_mant;
    logic [N*RB-1:0]   req_rbits;
    logic              out_valid;
    logic              out_ready;
    logic [IW-1:0]     out_id;
    logic              out_sign;
    logic [EW-1:0]     out_exp;
    logic [MW-1:0]     out_mant;
    logic              out_overflow;
`ifdef FPU_ROUND_STATS_EN
    logic              stat_clr = 1'b0;
    logic [N*16-1:0]   stat_grant_cnt;
    logic [15:0]       stat_ovf_cnt;
    int                exp_ovf_cnt = 0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    fpu_round_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_sign     (req_sign),
        .req_exp      (req_exp),
        .req_mant     (req_mant),
        .req_rbits    (req_rbits),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_id       (out_id),
        .out_sign     (out_sign),
        .out_exp      (out_exp),
        .out_mant     (out_mant),
        .out_overflow (out_overflow)
`ifdef FPU_ROUND_STATS_EN
        ,
        .stat_clr       (stat_clr),
        .stat_grant_cnt (stat_grant_cnt),
        .stat_ovf_cnt   (stat_ovf_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        s;
        logic [7:0]  e;
        logic [22:0] m;
        logic [2:0]  r;
        logic        xs;
        logic [7:0]  xe;
        logic [22:0] xm;
        logic        xo;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    function automatic logic [63:0] mk(input logic v, input logic [1:0] id, input logic s,
                                       input logic [7:0] e, input logic [22:0] m, input logic o);
        return {28'd0, v, id, s, e, m, o};
    endfunction

    function automatic logic [63:0] cur_out();
        return {28'd0, out_valid, out_id, out_sign, out_exp, out_mant, out_overflow};
    endfunction

    // Reference rounding from numeric value: remainder versus half an ulp, ties go to even
    function automatic logic [32:0] ref_round(input logic s, input int e, input int m, input int r);
        int half, nm, ne;
        logic up, carry, ovf;
        half  = 1 << (RB - 1);
        up    = (r > half) || (r == half && (m % 2) == 1);
        nm    = m + int'(up);
        carry = (nm == (1 << MW));
        nm    = nm % (1 << MW);
        ne    = (e + int'(carry)) % 256;
        ovf   = 1'b0;
        if (ne == 255) begin
            nm  = 0;
            ovf = 1'b1;
        end
        return {s, 8'(ne), 23'(nm), ovf};
    endfunction

    task automatic set_req(input int i, input logic s, input logic [7:0] e, input logic [22:0] m, input logic [2:0] r);
        req_sign[i]          = s;
        req_exp[i*EW +: EW]  = e;
        req_mant[i*MW +: MW] = m;
        req_rbits[i*RB +: RB] = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic        p_s [N];
    logic [7:0]  p_e [N];
    logic [22:0] p_m [N];
    logic [2:0]  p_r [N];
    logic        pend [N];

    initial begin : main
        logic        m_valid;
        logic [1:0]  m_id;
        logic [32:0] m_pay;
        int          m_ptr, w;
        logic        any, can;
        logic [N-1:0] x_ready;

        tbl[0] = '{1'b0, 8'h40, 23'h000001, 3'b100, 1'b0, 8'h40, 23'h000002, 1'b0};
        tbl[1] = '{1'b0, 8'h40, 23'h000002, 3'b100, 1'b0, 8'h40, 23'h000002, 1'b0};
        tbl[2] = '{1'b0, 8'h40, 23'h000002, 3'b101, 1'b0, 8'h40, 23'h000003, 1'b0};
        tbl[3] = '{1'b1, 8'h40, 23'h000002, 3'b011, 1'b1, 8'h40, 23'h000002, 1'b0};
        tbl[4] = '{1'b0, 8'h40, 23'h7FFFFF, 3'b110, 1'b0, 8'h41, 23'h000000, 1'b0};
        tbl[5] = '{1'b1, 8'hFE, 23'h7FFFFF, 3'b111, 1'b1, 8'hFF, 23'h000000, 1'b1};
        tbl[6] = '{1'b0, 8'h10, 23'h000005, 3'b100, 1'b0, 8'h10, 23'h000006, 1'b0};
        tbl[7] = '{1'b0, 8'h10, 23'h7FFFFF, 3'b100, 1'b0, 8'h11, 23'h000000, 1'b0};
        tbl[8] = '{1'b0, 8'hFE, 23'h7FFFFE, 3'b111, 1'b0, 8'hFE, 23'h7FFFFF, 1'b0};
        tbl[9] = '{1'b1, 8'h00, 23'h000000, 3'b000, 1'b1, 8'h00, 23'h000000, 1'b0};

        rst = 1'b1; req_valid = '0; out_ready = 1'b1;
        req_sign = '0; req_exp = '0; req_mant = '0; req_rbits = '0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 8'(8'h20 + i), 23'(i), 3'b000);
        req_valid = 4'b1111;
        #1;
        chk("reset_outputs", cur_out(), mk(1'b0, 2'd0, 1'b0, 8'h00, 23'h0, 1'b0));
        chk("reset_ready", 64'(req_ready), 64'h0);

        // Round-robin with all requesters valid and no backpressure
        rst = 1'b0;
        #1;
        chk("rr_first_ready", 64'(req_ready), 64'h1);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("rr_seq%0d", k), cur_out(), mk(1'b1, 2'(k % N), 1'b0, 8'(8'h20 + (k % N)), 23'(k % N), 1'b0));
        end

        // Backpressure: slot holds id 0, pointer now at 1
        out_ready = 1'b0;
        #1;
        chk("bp_ready0", 64'(req_ready), 64'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("bp_hold%0d", k), cur_out(), mk(1'b1, 2'd0, 1'b0, 8'h20, 23'h0, 1'b0));
            chk($sformatf("bp_ready%0d", k), 64'(req_ready), 64'h0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(req_ready), 64'h2);
        tick();
        chk("bp_release_out", cur_out(), mk(1'b1, 2'd1, 1'b0, 8'h21, 23'h1, 1'b0));

        // Directed rounding vectors through requester 0, back-to-back
        req_valid = 4'b0001;
        for (int t = 0; t < 10; t++) begin
            set_req(0, tbl[t].s, tbl[t].e, tbl[t].m, tbl[t].r);
            tick();
            chk($sformatf("round_vec%0d", t), cur_out(), mk(1'b1, 2'd0, tbl[t].xs, tbl[t].xe, tbl[t].xm, tbl[t].xo));
`ifdef FPU_ROUND_STATS_EN
            if (tbl[t].xo) exp_ovf_cnt++;
            chk($sformatf("stat_ovf%0d", t), 64'(stat_ovf_cnt), 64'(exp_ovf_cnt));
`endif
        end

        // Drain with no request leaves the pointer at 1
        req_valid = 4'b0000;
        tick();
        chk("drain_empty", 64'(out_valid), 64'h0);
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 8'(8'h20 + i), 23'(i), 3'b000);
        req_valid = 4'b1111;
        #1;
        chk("ptr_kept_ready", 64'(req_ready), 64'h2);
        tick();
        chk("ptr_kept_out", cur_out(), mk(1'b1, 2'd1, 1'b0, 8'h21, 23'h1, 1'b0));

        // Reset while the slot is occupied
        rst = 1'b1;
        #1;
        chk("midrst_valid", 64'(out_valid), 64'h0);
        chk("midrst_ready", 64'(req_ready), 64'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("postrst_ready", 64'(req_ready), 64'h1);
        tick();
        chk("postrst_out", cur_out(), mk(1'b1, 2'd0, 1'b0, 8'h20, 23'h0, 1'b0));

        // Randomized traffic against the reference model
        rst = 1'b1;
        req_valid = '0;
        tick();
        rst = 1'b0;
        m_valid = 1'b0; m_id = 2'd0; m_pay = '0; m_ptr = 0;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && ($urandom % 2 == 0)) begin
                    pend[i] = 1'b1;
                    p_s[i]  = 1'($urandom);
                    p_e[i]  = 8'($urandom_range(0, 254));
                    p_m[i]  = ($urandom % 6 == 0) ? 23'h7FFFFF : 23'($urandom);
                    p_r[i]  = 3'($urandom);
                end
                set_req(i, p_s[i], p_e[i], p_m[i], p_r[i]);
                req_valid[i] = pend[i];
            end
            out_ready = ($urandom % 4 != 0);
            #1;
            can = !m_valid || out_ready;
            any = 1'b0;
            w = 0;
            for (int k = 0; k < N; k++) begin
                if (!any && pend[(m_ptr + k) % N]) begin
                    any = 1'b1;
                    w = (m_ptr + k) % N;
                end
            end
            x_ready = (can && any) ? N'(1 << w) : '0;
            chk("rand_ready", 64'(req_ready), 64'(x_ready));
            if (can) begin
                if (any) begin
                    m_valid = 1'b1;
                    m_id    = 2'(w);
                    m_pay   = ref_round(p_s[w], int'(p_e[w]), int'(p_m[w]), int'(p_r[w]));
                    m_ptr   = (w + 1) % N;
                    pend[w] = 1'b0;
                end else begin
                    m_valid = 1'b0;
                end
            end
            tick();
            chk("rand_valid", 64'(out_valid), 64'(m_valid));
            if (m_valid) begin
                chk("rand_out", cur_out(), mk(1'b1, m_id, m_pay[32], m_pay[31:24], m_pay[23:1], m_pay[0]));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/fpu_round_arbiter.md
Name: fpu_round_arbiter

Overview:
- Shares one rounding stage (an instance of result_rounder) between NUM_REQ FPU producers (adder, multiplier, FMA, …).
- Each producer presents an unrounded {sign, exponent, mantissa, rounding_bits} with a valid/ready handshake.
- A round-robin arbiter picks one request per cycle, rounds it, and registers the result with a requester ID into a single output slot.
- The output slot drains to the writeback stage through its own valid/ready.

Parameters:
- NUM_REQ, 4, number of requesters (≥2)
- EXPONENT_WIDTH, 8, exponent bits
- MANTISSA_WIDTH, 23, stored mantissa bits (no hidden bit)
- ROUNDING_BITS, 3, guard/round/sticky bits per request (≥2)
- ID_WIDTH, $clog2(NUM_REQ), requester ID width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  request valid per requester
- req_ready  out  NUM_REQ  grant and accept; one-hot or zero
- req_sign  in  NUM_REQ  sign per requester
- req_exp  in  NUM_REQ*EXPONENT_WIDTH  packed exponents; requester i at [i*EW +: EW]
- req_mant  in  NUM_REQ*MANTISSA_WIDTH  packed mantissas
- req_rbits  in  NUM_REQ*ROUNDING_BITS  packed rounding bits
- out_valid  out  1  output slot occupied
- out_ready  in  1  consumer accepts
- out_id  out  ID_WIDTH  index of the requester that produced the result
- out_sign  out  1  result sign
- out_exp  out  EXPONENT_WIDTH  rounded exponent
- out_mant  out  MANTISSA_WIDTH  rounded mantissa
- out_overflow  out  1  rounding overflowed to infinity

Behaviour:
- Reset (async, active-high): out_valid=0, out_id=0, out_sign=0, out_exp=0, out_mant=0, out_overflow=0, rr_ptr=0. req_ready is 0 while rst is high.
- Slot may load when: can_load = !out_valid || out_ready.
- Arbitration (combinational):
  - Scan req_valid starting at rr_ptr, ascending with wrap, to pick the first set bit.
  - req_ready[g]=1 only for the winner g, and only when can_load. Otherwise req_ready=0.
  - req_ready never depends on req_valid of the same requester being deasserted later. Requesters must hold their payload stable until accepted.
- Transfer: on a rising clk with can_load and any req_valid set:
  - The slot captures the rounded payload of g, with out_id=g and out_valid=1.
  - rr_ptr becomes (g+1) mod NUM_REQ.
  - Latency from request to out_valid is 1 cycle.
- No request and out_ready=1: out_valid goes to 0 and rr_ptr is unchanged.
- Output held: while out_valid=1 and out_ready=0, all out_* stay stable and req_ready=0.
- Simultaneous drain and load: out_ready=1 with a pending request gives back-to-back results, one per cycle, with no bubble.
- Rounding is round-to-nearest, ties-to-even:
  - halfway = (rbits == 1 followed by zeros).
  - Round up if (halfway && mant[0]) || (!halfway && rbits[MSB]).
  - Round up adds 1 to the mantissa, wrapping at MANTISSA_WIDTH. On wrap to 0, exponent+1.
  - If the new exponent is all-ones: exp = all-ones, mant = 0, out_overflow = 1.
  - The sign passes through unchanged.
- Fairness: any continuously asserted requester is granted within NUM_REQ accepted transfers.
- Reset mid-operation: a pending output is dropped and rr_ptr returns to 0. No partial state survives.

Optional Feature:
- Macro FPU_ROUND_STATS_EN.
- When defined, adds these ports:
  - stat_clr (in, 1)
  - stat_grant_cnt (out, NUM_REQ*16): per-requester accepted-transfer counters
  - stat_ovf_cnt (out, 16): count of overflowed results
- Counters are zero on reset and zero on stat_clr, with stat_clr taking priority over increment in the same cycle.
- Counters saturate at 0xFFFF.
- When undefined, these ports and the counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: assert rst mid-transfer with out_valid=1 -> out_valid=0, req_ready=0 during reset. First grant after release goes to requester 0 when all requesters are valid.
- Round-robin: all 4 req_valid held high, out_ready=1 -> out_id sequence 0,1,2,3,0, one per cycle with no bubbles.
- Backpressure: out_ready=0 for 3 cycles after a load -> out_* stable, req_ready=0. Raising out_ready gives the next grant in the same cycle.
- Tie to even: mant=0x000001, rbits=3'b100, exp=0x40 -> mant=0x000002.
  - mant=0x000002, rbits=3'b100 -> mant=0x000002.
  - rbits=3'b101 -> round up.
- Mantissa carry: exp=0x40, mant=0x7FFFFF, rbits=3'b110 -> exp=0x41, mant=0, out_overflow=0.
- Overflow: exp=0xFE, mant=0x7FFFFF, rbits=3'b111, sign=1 -> exp=0xFF, mant=0, out_overflow=1, sign=1.
  - With FPU_ROUND_STATS_EN: stat_ovf_cnt goes 0 -> 1.
